// File: rtl/core_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package core_fetch_unit_pkg;

    localparam int unsigned FETCH_FIFO_DEPTH = 2;
    localparam logic [31:0] FETCH_BOOT_ADDR  = 32'h0000_0000;
    localparam int unsigned FETCH_PC_INC     = 4;

    typedef enum logic [1:0] {
        FETCH_ST_BOOT,
        FETCH_ST_RUN,
        FETCH_ST_HOLD
    } fetch_state_e;

endpackage

// File: rtl/core_fetch_unit_fifo.sv
// Synchronous FIFO with flush; used for the decode buffer and the in-flight PC queue.
module core_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count != '0);
    assign do_push = push_i && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i && !rst_i) mem[wr_ptr] <= data_i;
    end

    assign data_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/core_fetch_unit.sv
// Fetch stage: issues word requests, buffers responses, and flushes on branch redirect.
module core_fetch_unit
    import core_fetch_unit_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = FETCH_BOOT_ADDR,
    parameter int unsigned           FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] new_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    output logic                  misaligned_o
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_S = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e            state;
    logic [DATA_WIDTH-1:0]   fetch_pc;
    logic [DATA_WIDTH-1:0]   target_q;
    logic [DATA_WIDTH-1:0]   target;
    logic [CW-1:0]           outstanding;
    logic [CW-1:0]           out_next;
    logic [CW-1:0]           drop_cnt;
    logic [CW-1:0]           drop_next;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           pcq_count;
    logic [CW:0]             in_use;
    logic [2*DATA_WIDTH-1:0] fifo_head;
    logic [DATA_WIDTH-1:0]   pcq_head;
    logic                    misaligned_q;
    logic                    gnt_acc;
    logic                    rv_acc;
    logic                    rv_keep;
    logic                    req_stall;
    logic                    fifo_valid;
    logic                    fifo_pop;

    assign target     = {new_pc_i[DATA_WIDTH-1:2], 2'b00};
    assign in_use     = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_o = ((state == FETCH_ST_RUN) && (in_use < DEPTH_S)) || (state == FETCH_ST_HOLD);
    assign imem_addr_o = fetch_pc;
    assign gnt_acc    = imem_req_o && imem_gnt_i;
    assign req_stall  = imem_req_o && !imem_gnt_i;
    // Responses with nothing in flight (e.g. stragglers from before a reset) are ignored.
    assign rv_acc     = imem_rvalid_i && (pcq_count != '0);
    assign rv_keep    = rv_acc && (drop_cnt == '0) && !redirect_i;

    assign fifo_valid = (fifo_count != '0);
    assign fifo_pop   = fifo_valid && instr_ready_i && !redirect_i;

    always_comb begin
        case ({gnt_acc, rv_acc})
            2'b10:   out_next = outstanding + CW'(1);
            2'b01:   out_next = outstanding - CW'(1);
            default: out_next = outstanding;
        endcase
    end

    // On redirect everything still in flight after this edge becomes garbage.
    always_comb begin
        drop_next = drop_cnt;
        if (redirect_i) begin
            drop_next = out_next;
        end else begin
            if ((state == FETCH_ST_HOLD) && gnt_acc) drop_next = drop_next + CW'(1);
            if (rv_acc && (drop_cnt != '0))          drop_next = drop_next - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= FETCH_ST_BOOT;
            fetch_pc     <= BOOT_ADDR;
            target_q     <= BOOT_ADDR;
            outstanding  <= '0;
            drop_cnt     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            outstanding  <= out_next;
            drop_cnt     <= drop_next;
            misaligned_q <= redirect_i && (new_pc_i[1:0] != 2'b00);
            unique case (state)
                FETCH_ST_BOOT: begin
                    state <= FETCH_ST_RUN;
                    if (redirect_i) fetch_pc <= target;
                end
                FETCH_ST_RUN: begin
                    if (redirect_i && req_stall) begin
                        state    <= FETCH_ST_HOLD;
                        target_q <= target;
                    end else if (redirect_i) begin
                        fetch_pc <= target;
                    end else if (gnt_acc) begin
                        fetch_pc <= fetch_pc + DATA_WIDTH'(FETCH_PC_INC);
                    end
                end
                FETCH_ST_HOLD: begin
                    if (redirect_i) target_q <= target;
                    if (gnt_acc) begin
                        fetch_pc <= redirect_i ? target : target_q;
                        state    <= FETCH_ST_RUN;
                    end
                end
                default: state <= FETCH_ST_BOOT;
            endcase
        end
    end

    core_fetch_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (rv_keep),
        .data_i  ({imem_rdata_i, pcq_head}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    // Tracks the address of every granted request, dropped or not, in response order.
    core_fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (gnt_acc),
        .data_i  (fetch_pc),
        .pop_i   (rv_acc),
        .data_o  (pcq_head),
        .count_o (pcq_count)
    );

    assign instr_valid_o = fifo_valid;
    assign instr_o       = fifo_valid ? fifo_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign instr_pc_o    = fifo_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign misaligned_o  = misaligned_q;

endmodule
